// File: rtl/dmem_lsu.sv
// Load/store initiator for four byte-wide data-memory banks: one request at a time,
// any alignment, a single bank cycle per access, and sign/zero-extended load return.
module dmem_lsu #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic [31:0]             resp_rdata,
    output logic [4*(ADDR_W-2)-1:0] bank_addr,
    output logic [3:0]              bank_re,
    output logic [3:0]              bank_we,
    output logic [31:0]             bank_wdata,
    input  logic [31:0]             bank_rdata
);
    localparam int ROW_W = ADDR_W - 2;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no backpressure.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic [1:0]             off_q, off_d;
    logic                   uns_q, uns_d;

    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic [4*ROW_W-1:0]     bank_addr_q, bank_addr_d;
    logic [3:0]             bank_re_q, bank_re_d;
    logic [3:0]             bank_we_q, bank_we_d;
    logic [31:0]            bank_wdata_q, bank_wdata_d;

    logic [1:0]             off;
    logic [1:0]             rel;
    logic [ROW_W-1:0]       row_w, row_w1;
    logic [3:0]             lane_mask;
    logic [4*ROW_W-1:0]     lane_addr;
    logic [31:0]            lane_wdata;
    logic [63:0]            rot;
    logic [31:0]            load_ext;

    // Lane b carries access byte rel = b - off; lanes below the offset spill into the next row.
    always_comb begin
        off        = req_addr[1:0];
        row_w      = req_addr[ADDR_W-1:2];
        row_w1     = (row_w == ROW_W'(DEPTH - 1)) ? '0 : row_w + ROW_W'(1);
        lane_mask  = '0;
        lane_addr  = '0;
        lane_wdata = '0;
        rel        = '0;
        for (int b = 0; b < 4; b++) begin
            rel = 2'(b) - off;
            case (req_size)
                2'b00:   lane_mask[b] = (rel == 2'd0);
                2'b01:   lane_mask[b] = ~rel[1];
                2'b10:   lane_mask[b] = 1'b1;
                default: lane_mask[b] = 1'b0;
            endcase
            if (lane_mask[b]) begin
                lane_addr[b*ROW_W +: ROW_W] = (2'(b) >= off) ? row_w : row_w1;
                lane_wdata[8*b +: 8]        = req_wdata[{rel, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        rot = {bank_rdata, bank_rdata} >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{rot[7]  & ~uns_q}}, rot[7:0]};
            2'b01:   load_ext = {{16{rot[15] & ~uns_q}}, rot[15:0]};
            default: load_ext = rot[31:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        bank_addr_d  = bank_addr_q;
        bank_re_d    = '0;
        bank_we_d    = '0;
        bank_wdata_d = bank_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    off_d  = off;
                    uns_d  = req_unsigned;
                    if (req_size == 2'b11) begin
                        state_d = COLLECT;
                    end else begin
                        state_d      = ISSUE;
                        bank_re_d    = req_we ? 4'b0000 : lane_mask;
                        bank_we_d    = req_we ? lane_mask : 4'b0000;
                        bank_addr_d  = lane_addr;
                        bank_wdata_d = req_we ? lane_wdata : 32'h0;
                    end
                end
            end
            ISSUE: begin
                // A store is finished once its strobe is out, so it skips the read collect cycle.
                if (we_q) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'h0;
                end else begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                if (size_q == 2'b11) begin
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end else begin
                    resp_rdata_d = load_ext;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            bank_addr_q  <= '0;
            bank_re_q    <= '0;
            bank_we_q    <= '0;
            bank_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            bank_addr_q  <= bank_addr_d;
            bank_re_q    <= bank_re_d;
            bank_we_q    <= bank_we_d;
            bank_wdata_q <= bank_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign bank_addr  = bank_addr_q;
    assign bank_re    = bank_re_q;
    assign bank_we    = bank_we_q;
    assign bank_wdata = bank_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: four synchronous byte banks, a flat byte-array model of memory,
// and a per-cycle compare of strobes, responses and ready against expected queues.
module tb_dmem_lsu;
    localparam int DEPTH = 16384;
    localparam int AW    = 16;
    localparam int RW    = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic [4*RW-1:0] bank_addr;
    logic [3:0]    bank_re;
    logic [3:0]    bank_we;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;

    dmem_lsu #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .bank_addr(bank_addr), .bank_re(bank_re), .bank_we(bank_we),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Four byte banks with one-cycle read latency.
    logic [7:0] bmem [4][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_we[b]) bmem[b][bank_addr[b*RW +: RW]] <= bank_wdata[8*b +: 8];
            if (bank_re[b]) bank_rdata[8*b +: 8] <= bmem[b][bank_addr[b*RW +: RW]];
        end
    end

    // Flat byte-addressed reference memory.
    logic [7:0] fmem [65536];

    typedef struct {
        int              cyc;
        logic [3:0]      re;
        logic [3:0]      we;
        logic [4*RW-1:0] addr;
        logic [31:0]     wd;
    } iss_t;
    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   ready_at = 0;
    bit   mon_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // scoreboard: compare every cycle after reset
    always @(negedge clk) begin
        if (mon_en) begin
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                chk("iss_re", 64'(bank_re), 64'(iss_q[0].re));
                chk("iss_we", 64'(bank_we), 64'(iss_q[0].we));
                chk("iss_addr", 64'(bank_addr), 64'(iss_q[0].addr));
                chk("iss_wdata", 64'(bank_wdata), 64'(iss_q[0].wd));
                void'(iss_q.pop_front());
            end else begin
                chk("quiet_re", 64'(bank_re), 64'h0);
                chk("quiet_we", 64'(bank_we), 64'h0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                chk("rsp_valid", 64'(resp_valid), 64'h1);
                chk("rsp_err", 64'(resp_err), 64'(rsp_q[0].err));
                chk("rsp_rdata", 64'(resp_rdata), 64'(rsp_q[0].rd));
                void'(rsp_q.pop_front());
            end else begin
                chk("no_rsp", 64'(resp_valid), 64'h0);
            end
            chk("ready", 64'(req_ready), 64'(cyc >= ready_at));
        end
    end

    // driver: starts and ends just after a falling edge
    task automatic do_req(input logic we, input logic [15:0] a, input logic [1:0] s,
                          input logic u, input logic [31:0] wd, input bit hold, input bit abort,
                          output logic [3:0] m, output logic [4*RW-1:0] av,
                          output logic [31:0] wv, output logic [31:0] rd);
        int t, k, guard;
        logic [15:0] ba;
        iss_t e;
        rsp_t r;
        guard = 0;
        while (cyc < ready_at && guard < 50) begin
            @(negedge clk); #2;
            guard++;
        end
        if (guard >= 50) chk("wait_ready_timeout", 64'(guard), 64'h0);
        t = cyc + 1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd;
        m = '0; av = '0; wv = '0; rd = '0;
        if (s == 2'b11) begin
            r.cyc = t + 1; r.err = 1'b1; r.rd = 32'h0;
            rsp_q.push_back(r);
            ready_at = t + 1;
        end else begin
            k = 1 << s;
            for (int i = 0; i < k; i++) begin
                ba = a + 16'(i);
                m[ba[1:0]] = 1'b1;
                av[ba[1:0]*RW +: RW] = ba[15:2];
                if (we) begin
                    wv[ba[1:0]*8 +: 8] = wd[8*i +: 8];
                    fmem[ba] = wd[8*i +: 8];
                end else begin
                    rd[8*i +: 8] = fmem[ba];
                end
            end
            if (!we && !u && k < 4 && rd[8*k-1])
                for (int j = k; j < 4; j++) rd[8*j +: 8] = 8'hFF;
            e.cyc = t; e.re = we ? 4'b0 : m; e.we = we ? m : 4'b0; e.addr = av; e.wd = wv;
            iss_q.push_back(e);
            r.cyc = we ? t + 1 : t + 2; r.err = 1'b0; r.rd = we ? 32'h0 : rd;
            rsp_q.push_back(r);
            ready_at = we ? t + 1 : t + 2;
        end
        @(negedge clk); #2;
        if (abort) begin
            rst = 1'b1;
            req_valid = 1'b0;
            void'(rsp_q.pop_back());
            ready_at = t + 1;
            @(negedge clk); #2;
            chk("rst_mid_ready", 64'(req_ready), 64'h1);
            chk("rst_mid_err", 64'(resp_err), 64'h0);
            chk("rst_mid_rdata", 64'(resp_rdata), 64'h0);
            chk("rst_mid_addr", 64'(bank_addr), 64'h0);
            chk("rst_mid_wdata", 64'(bank_wdata), 64'h0);
            rst = 1'b0;
        end else begin
            guard = 0;
            while (cyc < ready_at && guard < 50) begin
                req_valid = hold;
                if (hold) begin
                    req_we    = 1'($urandom_range(0, 1));
                    req_addr  = 16'($urandom_range(0, 65535));
                    req_size  = 2'($urandom_range(0, 3));
                    req_wdata = $urandom;
                end
                @(negedge clk); #2;
                guard++;
            end
            req_valid = 1'b0;
        end
    endtask

    logic [3:0]      m;
    logic [4*RW-1:0] av;
    logic [31:0]     wv;
    logic [31:0]     rd;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'h1);
        chk("reset_valid", 64'(resp_valid), 64'h0);
        chk("reset_err", 64'(resp_err), 64'h0);
        chk("reset_rdata", 64'(resp_rdata), 64'h0);
        chk("reset_re", 64'(bank_re), 64'h0);
        chk("reset_we", 64'(bank_we), 64'h0);
        chk("reset_addr", 64'(bank_addr), 64'h0);
        chk("reset_wdata", 64'(bank_wdata), 64'h0);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;

        do_req(1'b1, 16'h0100, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, m, av, wv, rd);
        chk("st_word_mask", 64'(m), 64'hF);
        chk("st_word_rows", 64'(av), 64'({4{14'h040}}));
        chk("st_word_lanes", 64'(wv), 64'hDEADBEEF);
        do_req(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_word_val", 64'(rd), 64'hDEADBEEF);

        do_req(1'b1, 16'h0103, 2'b01, 1'b0, 32'h0000A55A, 1'b1, 1'b0, m, av, wv, rd);
        chk("st_half_mask", 64'(m), 64'h9);
        chk("st_half_rows", 64'(av), 64'({14'h040, 14'h000, 14'h000, 14'h041}));
        chk("st_half_lanes", 64'(wv), 64'h5A0000A5);
        do_req(1'b0, 16'h0103, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, m, av, wv, rd);
        chk("ld_half_s", 64'(rd), 64'hFFFFA55A);
        do_req(1'b0, 16'h0103, 2'b01, 1'b1, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_half_u", 64'(rd), 64'h0000A55A);

        do_req(1'b1, 16'h0202, 2'b00, 1'b0, 32'h00000080, 1'b0, 1'b0, m, av, wv, rd);
        do_req(1'b0, 16'h0202, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_byte_s", 64'(rd), 64'hFFFFFF80);
        chk("ld_byte_mask", 64'(m), 64'h4);
        do_req(1'b0, 16'h0202, 2'b00, 1'b1, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_byte_u", 64'(rd), 64'h00000080);

        do_req(1'b1, 16'hFFFE, 2'b10, 1'b0, 32'h11223344, 1'b1, 1'b0, m, av, wv, rd);
        chk("wrap_rows", 64'(av), 64'({14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000}));
        chk("wrap_lanes", 64'(wv), 64'h33441122);
        do_req(1'b0, 16'hFFFE, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("wrap_ld", 64'(rd), 64'h11223344);

        do_req(1'b0, 16'h0100, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0, m, av, wv, rd);
        chk("err_mask", 64'(m), 64'h0);

        do_req(1'b0, 16'h0101, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_mis_word", 64'(rd), 64'hA55AADBE);

        do_req(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, m, av, wv, rd);
        do_req(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_after_rst", 64'(rd), 64'h5AADBEEF);

        do_req(1'b1, 16'h0301, 2'b01, 1'b0, 32'h00007F01, 1'b0, 1'b0, m, av, wv, rd);
        do_req(1'b0, 16'h0301, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, m, av, wv, rd);
        chk("ld_half_pos", 64'(rd), 64'h00007F01);

        repeat (4) @(negedge clk);
        #2;
        chk("drain_rsp", 64'(rsp_q.size()), 64'h0);
        chk("drain_iss", 64'(iss_q.size()), 64'h0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
